// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI target block.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, ABORT} spi_slave_state_t;

  // Only CPHA=0 timing is implemented; CPOL picks the idle level of SCLK.
  localparam bit CPHA0     = 1'b0;
  localparam bit CPOL_LOW  = 1'b0;
  localparam bit CPOL_HIGH = 1'b1;

  // Picks the SCLK edge that moves away from the idle level.
  // Call with (rise, fall) for the lead edge, or (fall, rise) for the trail edge.
  function automatic logic sel_edge(input logic cpol, input logic rise, input logic fall);
    return cpol ? fall : rise;
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Fabric-side word handshake for the SPI target.
interface spi_slave_if #(parameter int DWIDTH = 32);
  logic              tx_valid;
  logic              tx_ready;
  logic [DWIDTH-1:0] tx_data;
  logic              rx_valid;
  logic [DWIDTH-1:0] rx_data;
  logic              tx_underrun;
  logic              frame_err;
  logic              busy;

  modport slave  (input  tx_valid, tx_data,
                  output tx_ready, rx_valid, rx_data, tx_underrun, frame_err, busy);
  modport master (output tx_valid, tx_data,
                  input  tx_ready, rx_valid, rx_data, tx_underrun, frame_err, busy);
endinterface

// File: rtl/spi_slave_input_sync.sv
// Multi-flop synchronizer plus one history flop for edge detection.
module spi_input_sync #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Shift the pin through the chain; reset parks everything at the idle level
  // so that leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o =  q_o & ~hist_q;
  assign fall_o = ~q_o &  hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI target (CPHA=0) running entirely in the system clock domain.
module spi_slave import spi_pkg::*; #(
  parameter int DWIDTH      = 32,
  parameter bit CPOL        = CPOL_HIGH,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_sclk,
  input  logic spi_ss_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  spi_slave_if.slave bus
);

  localparam int             CW   = $clog2(DWIDTH);
  localparam logic [CW-1:0]  LAST = CW'(DWIDTH - 1);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
  logic sclk_unused, ss_unused, mosi_rise_unused, mosi_fall_unused;
  logic lead, trail;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .reset(reset), .d_i(spi_sclk),
    .q_o(sclk_unused), .rise_o(sclk_rise), .fall_o(sclk_fall));

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .d_i(spi_ss_n),
    .q_o(ss_unused), .rise_o(ss_rise), .fall_o(ss_fall));

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d_i(spi_mosi),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused));

  assign lead  = sel_edge(CPOL, sclk_rise, sclk_fall);
  assign trail = sel_edge(CPOL, sclk_fall, sclk_rise);

  spi_slave_state_t  state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DWIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DWIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DWIDTH-1:0] rx_data_q, rx_data_d;
  logic [DWIDTH-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic              frame_err_q, frame_err_d;
  logic              ur_pend_q, ur_pend_d;
  logic              consume;

  // Frame sequencing, shifting and the holding register.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    ur_pend_d   = ur_pend_q;
    consume     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = SHIFT;
          bit_cnt_d  = '0;
          rx_sh_d    = '0;
          consume    = 1'b1;
          tx_sh_d    = hold_full_q ? hold_q : '0;
          underrun_d = ~hold_full_q;
          ur_pend_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          // A rise on SS beats any SCLK edge seen in the same cycle.
          frame_err_d = (bit_cnt_q != '0);
          ur_pend_d   = 1'b0;
          state_d     = ABORT;
        end else if (lead) begin
          rx_sh_d    = {rx_sh_q[DWIDTH-2:0], mosi_s};
          // A streamed word that started empty is only reported once the
          // master actually clocks it, so the closing trail edge of a frame
          // does not raise a false underrun.
          underrun_d = ur_pend_q;
          ur_pend_d  = 1'b0;
          if (bit_cnt_q == LAST) begin
            bit_cnt_d  = '0;
            rx_data_d  = rx_sh_d;
            rx_valid_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (trail) begin
          if (bit_cnt_q != '0) begin
            tx_sh_d = tx_sh_q << 1;
          end else begin
            consume   = 1'b1;
            tx_sh_d   = hold_full_q ? hold_q : '0;
            ur_pend_d = ~hold_full_q;
          end
        end
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new word may land in the same cycle an empty holder is "consumed".
    hold_d      = hold_q;
    hold_full_d = hold_full_q & ~consume;
    if (bus.tx_valid && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ur_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
      ur_pend_q   <= ur_pend_d;
    end
  end

  assign spi_miso_oe     = (state_q != IDLE);
  assign spi_miso        = spi_miso_oe & tx_sh_q[DWIDTH-1];
  assign bus.busy        = (state_q != IDLE);
  assign bus.tx_ready    = ~hold_full_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench: drives a CPOL=1 and a CPOL=0 target in lockstep (SCLK inverted for the
// latter) and scoreboards received words against the words the master sent.
module tb_spi_slave;

  logic clk = 1'b0;
  logic reset;
  logic sclk, ss_n, mosi;
  logic sclk0;
  logic miso1, oe1, miso0, oe0;
  logic        tx_valid;
  logic [31:0] tx_data;

  int checks = 0;
  int errs   = 0;
  int nrx1 = 0, nrx0 = 0, nur1 = 0, nur0 = 0, nfe1 = 0, nfe0 = 0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];

  always #5 clk = ~clk;
  assign sclk0 = ~sclk;

  spi_slave_if #(.DWIDTH(32)) if1();
  spi_slave_if #(.DWIDTH(32)) if0();
  assign if1.tx_valid = tx_valid;
  assign if1.tx_data  = tx_data;
  assign if0.tx_valid = tx_valid;
  assign if0.tx_data  = tx_data;

  spi_slave #(.DWIDTH(32), .CPOL(1'b1), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .reset(reset), .spi_sclk(sclk), .spi_ss_n(ss_n), .spi_mosi(mosi),
    .spi_miso(miso1), .spi_miso_oe(oe1), .bus(if1.slave));

  spi_slave #(.DWIDTH(32), .CPOL(1'b0), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .reset(reset), .spi_sclk(sclk0), .spi_ss_n(ss_n), .spi_mosi(mosi),
    .spi_miso(miso0), .spi_miso_oe(oe0), .bus(if0.slave));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard / pulse monitors.
  always @(negedge clk) begin
    if (!reset) begin
      if (if1.rx_valid) begin
        nrx1++;
        if (q1.size() == 0) chk("rx1_unexpected", {32'h0, if1.rx_data}, 64'hx);
        else chk("rx1", {32'h0, if1.rx_data}, {32'h0, q1.pop_front()});
      end
      if (if0.rx_valid) begin
        nrx0++;
        if (q0.size() == 0) chk("rx0_unexpected", {32'h0, if0.rx_data}, 64'hx);
        else chk("rx0", {32'h0, if0.rx_data}, {32'h0, q0.pop_front()});
      end
      if (if1.tx_underrun) nur1++;
      if (if0.tx_underrun) nur0++;
      if (if1.frame_err)   nfe1++;
      if (if0.frame_err)   nfe0++;
    end
  end

  task automatic load(input logic [31:0] d);
    int n;
    n = 0;
    while (!(if1.tx_ready && if0.tx_ready) && n < 100) begin
      tick(1);
      n++;
    end
    chk("load_wait", (n < 100), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    chk("tx_ready_fall", {if1.tx_ready, if0.tx_ready}, 0);
  endtask

  // Master: MOSI changes on trail, MISO sampled just before each trail edge.
  task automatic frame(input logic [63:0] w, input int nbits, input int hp, input bit raise,
                       output logic [63:0] m1, output logic [63:0] m0,
                       output logic p1, output logic p0);
    m1   = '0;
    m0   = '0;
    mosi = w[63];
    ss_n = 1'b0;
    tick((hp < 6) ? 6 : hp);
    p1 = miso1;
    p0 = miso0;
    chk("busy_oe", {if1.busy, oe1, if0.busy, oe0}, 4'hf);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      tick(hp);
      m1[63-i] = miso1;
      m0[63-i] = miso0;
      sclk = 1'b1;
      if (i < 63) mosi = w[62-i];
      tick(hp);
    end
    if (raise) begin
      ss_n = 1'b1;
      tick(10);
    end
  endtask

  typedef struct {
    logic [31:0] tx;
    bit          pre;
    logic [31:0] mosi;
    logic [31:0] exp_miso;
    int          exp_ur;
  } vec_t;

  vec_t vec[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] m1, m0;
    logic p1, p0;
    int ur1, ur0, fe1, fe0, rx1, rx0;

    vec[0] = '{32'hA5A5_0F0F, 1'b1, 32'h1234_5678, 32'hA5A5_0F0F, 0};
    vec[1] = '{32'h0000_0000, 1'b0, 32'h0000_00FF, 32'h0000_0000, 1};
    vec[2] = '{32'hFFFF_FFFF, 1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 0};
    vec[3] = '{32'h3C3C_00FF, 1'b1, 32'h0000_0000, 32'h3C3C_00FF, 0};

    reset = 1'b1; sclk = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    tick(3);
    chk("rst_ready",  {if1.tx_ready, if0.tx_ready}, 2'b11);
    chk("rst_rxv",    {if1.rx_valid, if0.rx_valid}, 0);
    chk("rst_rxdata", {if1.rx_data, if0.rx_data}, 0);
    chk("rst_pins",   {miso1, oe1, miso0, oe0}, 0);
    chk("rst_flags",  {if1.tx_underrun, if1.frame_err, if1.busy,
                       if0.tx_underrun, if0.frame_err, if0.busy}, 0);
    reset = 1'b0;
    tick(3);

    // Single frames, SCLK = clk/8.
    foreach (vec[k]) begin
      ur1 = nur1; ur0 = nur0; fe1 = nfe1; fe0 = nfe0;
      if (vec[k].pre) load(vec[k].tx);
      q1.push_back(vec[k].mosi);
      q0.push_back(vec[k].mosi);
      frame({vec[k].mosi, 32'h0}, 32, 4, 1'b1, m1, m0, p1, p0);
      chk("miso1", m1[63:32], vec[k].exp_miso);
      chk("miso0", m0[63:32], vec[k].exp_miso);
      chk("msb_pre", {p1, p0}, {2{vec[k].exp_miso[31]}});
      chk("underrun", {nur1 - ur1, nur0 - ur0}, {vec[k].exp_ur, vec[k].exp_ur});
      chk("frame_err", {nfe1 - fe1, nfe0 - fe0}, 0);
      chk("rx_drain", {q1.size(), q0.size()}, 0);
      chk("ready_end", {if1.tx_ready, if0.tx_ready}, 2'b11);
      chk("idle_end", {if1.busy, oe1, miso1, if0.busy, oe0, miso0}, 0);
    end

    // Streaming: two words under one SS, second word loaded mid-frame.
    ur1 = nur1; fe1 = nfe1; rx1 = nrx1; rx0 = nrx0;
    load(32'h1111_1111);
    q1.push_back(32'hDEAD_BEEF); q1.push_back(32'hCAFE_F00D);
    q0.push_back(32'hDEAD_BEEF); q0.push_back(32'hCAFE_F00D);
    fork
      frame({32'hDEAD_BEEF, 32'hCAFE_F00D}, 64, 4, 1'b1, m1, m0, p1, p0);
      begin tick(20); load(32'h2222_2222); end
    join
    chk("stream_miso1", m1, 64'h1111_1111_2222_2222);
    chk("stream_miso0", m0, 64'h1111_1111_2222_2222);
    chk("stream_rxcnt", {nrx1 - rx1, nrx0 - rx0}, {32'd2, 32'd2});
    chk("stream_ur_fe", {nur1 - ur1, nfe1 - fe1}, 0);
    chk("stream_drain", {q1.size(), q0.size()}, 0);

    // Abort after 13 bits, then a clean frame.
    fe1 = nfe1; fe0 = nfe0; rx1 = nrx1; rx0 = nrx0; ur1 = nur1;
    load(32'h1357_2468);
    frame({32'hFFFF_FFFF, 32'h0}, 13, 4, 1'b1, m1, m0, p1, p0);
    chk("abort_fe", {nfe1 - fe1, nfe0 - fe0}, {32'd1, 32'd1});
    chk("abort_norx", {nrx1 - rx1, nrx0 - rx0}, 0);
    chk("abort_ur", nur1 - ur1, 0);
    chk("abort_ready", {if1.tx_ready, if0.tx_ready}, 2'b11);
    fe1 = nfe1;
    load(32'h0BAD_F00D);
    q1.push_back(32'h0F0F_1234); q0.push_back(32'h0F0F_1234);
    frame({32'h0F0F_1234, 32'h0}, 32, 4, 1'b1, m1, m0, p1, p0);
    chk("post_abort_miso", {m1[63:32], m0[63:32]}, {32'h0BAD_F00D, 32'h0BAD_F00D});
    chk("post_abort_fe", nfe1 - fe1, 0);
    chk("post_abort_drain", {q1.size(), q0.size()}, 0);

    // Reset at bit 20.
    fe1 = nfe1; fe0 = nfe0; rx1 = nrx1; rx0 = nrx0;
    load(32'h2468_1357);
    frame({32'hAAAA_5555, 32'h0}, 20, 4, 1'b0, m1, m0, p1, p0);
    reset = 1'b1;
    tick(1);
    chk("rst_mid_ready", {if1.tx_ready, if0.tx_ready}, 2'b11);
    chk("rst_mid_pins", {miso1, oe1, if1.busy, miso0, oe0, if0.busy}, 0);
    chk("rst_mid_flags", {if1.rx_valid, if1.tx_underrun, if1.frame_err,
                          if0.rx_valid, if0.tx_underrun, if0.frame_err}, 0);
    chk("rst_mid_rxdata", {if1.rx_data, if0.rx_data}, 0);
    ss_n = 1'b1;
    tick(4);
    reset = 1'b0;
    tick(4);
    chk("rst_mid_nofe", {nfe1 - fe1, nfe0 - fe0}, 0);
    chk("rst_mid_norx", {nrx1 - rx1, nrx0 - rx0}, 0);
    load(32'h55AA_33CC);
    q1.push_back(32'h600D_CAFE); q0.push_back(32'h600D_CAFE);
    frame({32'h600D_CAFE, 32'h0}, 32, 4, 1'b1, m1, m0, p1, p0);
    chk("post_rst_miso", {m1[63:32], m0[63:32]}, {32'h55AA_33CC, 32'h55AA_33CC});
    chk("post_rst_drain", {q1.size(), q0.size()}, 0);

    // Minimum ratio: SCLK = clk/4.
    ur1 = nur1; fe1 = nfe1;
    load(32'h8000_0001);
    q1.push_back(32'h8000_0001); q0.push_back(32'h8000_0001);
    frame({32'h8000_0001, 32'h0}, 32, 2, 1'b1, m1, m0, p1, p0);
    chk("fast_msb_pre", {p0, p1}, 2'b11);
    chk("fast_miso", {m1[63:32], m0[63:32]}, {32'h8000_0001, 32'h8000_0001});
    chk("fast_ur_fe", {nur1 - ur1, nfe1 - fe1}, 0);
    chk("fast_drain", {q1.size(), q0.size()}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
